// File: rtl/axi_ar_arbiter.sv
// AXI read-address arbiter for three masters with a local DECERR responder for unmapped reads.
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority M0 > M1 > M2.
module axi_ar_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int LEN_W   = 4,
  parameter int DEF_SLV = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          m_arvalid,
  input  logic [3*ADDR_W-1:0] m_araddr,
  input  logic [3*ID_W-1:0]   m_arid,
  input  logic [3*LEN_W-1:0]  m_arlen,
  output logic [2:0]          m_arready,
  output logic [ADDR_W-1:0]   dec_addr,
  input  logic [3:0]          dec_slave_id,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ID_W+1:0]     s_arid,
  output logic [LEN_W-1:0]    s_arlen,
  output logic [3:0]          s_sel,
  input  logic                s_rvalid,
  input  logic                s_rlast,
  input  logic [1:0]          s_rresp,
  output logic                s_rready,
  output logic [2:0]          m_rvalid,
  input  logic [2:0]          m_rready,
  output logic                m_rlast,
  output logic [1:0]          m_rresp,
  output logic [ID_W-1:0]     m_rid,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DEC  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [3:0] DEF_ID = 4'(DEF_SLV);

  state_t             state_r;
  logic [1:0]         grant_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [ID_W-1:0]    id_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W:0]     cnt_r;
  logic [3:0]         sel_r;
  logic               arvalid_r;
  logic               busy_r;
  logic [1:0]         start_s;
  logic [2:0]         win_s;
  logic               last_s;
  logic               done_s;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    if (x == 2'd2) begin
      inc3 = 2'd0;
    end else begin
      inc3 = x + 2'd1;
    end
  endfunction

  // Returns {found, index}: first requester scanning start, start+1, start+2 (mod 3).
  function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] start);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = inc3(start);
    c2 = inc3(c1);
    if (req[start]) begin
      pick = {1'b1, start};
    end else if (req[c1]) begin
      pick = {1'b1, c1};
    end else if (req[c2]) begin
      pick = {1'b1, c2};
    end else begin
      pick = 3'b000;
    end
  endfunction

`ifdef ARB_RR_EN
  logic [1:0] ptr_r;

  // Round-robin pointer advances past the master whose transaction just completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 2'd0;
    end else if (done_s) begin
      ptr_r <= inc3(grant_r);
    end
  end

  assign start_s = ptr_r;
`else
  assign start_s = 2'd0;
`endif

  assign win_s  = pick(m_arvalid, start_s);
  assign last_s = (cnt_r == {1'b0, len_r});
  assign done_s = ((state_r == DATA) && s_rvalid && m_rready[grant_r] && s_rlast) ||
                  ((state_r == ERR) && m_rready[grant_r] && last_s);

  // Transaction sequencer: latch request, decode, issue AR, then route or synthesise R beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      grant_r   <= 2'd0;
      addr_r    <= '0;
      id_r      <= '0;
      len_r     <= '0;
      cnt_r     <= '0;
      sel_r     <= 4'd0;
      arvalid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_s[2]) begin
            grant_r <= win_s[1:0];
            addr_r  <= m_araddr[win_s[1:0]*ADDR_W +: ADDR_W];
            id_r    <= m_arid[win_s[1:0]*ID_W +: ID_W];
            len_r   <= m_arlen[win_s[1:0]*LEN_W +: LEN_W];
            busy_r  <= 1'b1;
            state_r <= DEC;
          end
        end
        DEC: begin
          sel_r <= dec_slave_id;
          if (dec_slave_id == DEF_ID) begin
            state_r <= ERR;
          end else begin
            arvalid_r <= 1'b1;
            state_r   <= ADDR;
          end
        end
        ADDR: begin
          if (s_arready) begin
            arvalid_r <= 1'b0;
            state_r   <= DATA;
          end
        end
        DATA: begin
          if (done_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ERR: begin
          if (m_rready[grant_r]) begin
            if (last_s) begin
              cnt_r   <= '0;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r + {{LEN_W{1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          arvalid_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Handshake steering: AR ready only while arbitrating, R path only in DATA/ERR.
  always_comb begin
    m_arready = 3'b000;
    m_rvalid  = 3'b000;
    s_rready  = 1'b0;
    m_rlast   = 1'b0;
    m_rresp   = 2'b00;
    case (state_r)
      IDLE: begin
        if (win_s[2]) begin
          m_arready[win_s[1:0]] = 1'b1;
        end else begin
          m_arready = 3'b000;
        end
      end
      DATA: begin
        m_rvalid[grant_r] = s_rvalid;
        s_rready          = m_rready[grant_r];
        m_rlast           = s_rlast;
        m_rresp           = s_rresp;
      end
      ERR: begin
        m_rvalid[grant_r] = 1'b1;
        m_rresp           = 2'b11;
        m_rlast           = last_s;
      end
      default: begin
        m_arready = 3'b000;
      end
    endcase
  end

  assign dec_addr  = addr_r;
  assign s_arvalid = arvalid_r;
  assign s_araddr  = addr_r;
  assign s_arid    = {grant_r, id_r};
  assign s_arlen   = len_r;
  assign s_sel     = sel_r;
  assign m_rid     = id_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed and randomized bench for axi_ar_arbiter with a transaction-level reference model.
module tb_axi_ar_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  m_arvalid;
  logic [95:0] m_araddr;
  logic [11:0] m_arid;
  logic [11:0] m_arlen;
  logic [2:0]  m_arready;
  logic [31:0] dec_addr;
  logic [3:0]  dec_slave_id;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic [5:0]  s_arid;
  logic [3:0]  s_arlen;
  logic [3:0]  s_sel;
  logic        s_rvalid;
  logic        s_rlast;
  logic [1:0]  s_rresp;
  logic        s_rready;
  logic [2:0]  m_rvalid;
  logic [2:0]  m_rready;
  logic        m_rlast;
  logic [1:0]  m_rresp;
  logic [3:0]  m_rid;
  logic        busy;

  logic [31:0] a_addr [3];
  logic [3:0]  a_id   [3];
  logic [3:0]  a_len  [3];

  int errors = 0;
  int checks = 0;
  int mptr   = 0;

  axi_ar_arbiter dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arready(m_arready), .dec_addr(dec_addr), .dec_slave_id(dec_slave_id),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_sel(s_sel), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
    .s_rresp(s_rresp), .s_rready(s_rready), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rlast(m_rlast), .m_rresp(m_rresp), .m_rid(m_rid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_araddr = {a_addr[2], a_addr[1], a_addr[0]};
  assign m_arid   = {a_id[2], a_id[1], a_id[0]};
  assign m_arlen  = {a_len[2], a_len[1], a_len[0]};

  // Address map: 0x3xxx_xxxx is unmapped (slave 6), otherwise slave = addr[17:16].
  function automatic logic [3:0] dec_of(input logic [31:0] a);
    if (a[31:28] == 4'h3) return 4'd6;
    return {2'b00, a[17:16]};
  endfunction

  assign dec_slave_id = dec_of(dec_addr);

  function automatic logic [31:0] rand_addr(input bit unmapped);
    if (unmapped) return {4'h3, 28'($urandom)};
    return {4'h0, 12'($urandom), 16'($urandom)};
  endfunction

  function automatic int exp_winner(input logic [2:0] reqs);
    for (int k = 0; k < 3; k++) begin
      int idx;
`ifdef ARB_RR_EN
      idx = (mptr + k) % 3;
`else
      idx = k;
`endif
      if (reqs[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [2:0] rready_pat(input int mode, input int cyc);
    if (mode == 0) return 3'b111;
    if (mode == 2) return (cyc % 2 == 0) ? 3'b111 : 3'b000;
    return 3'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_arready"}, m_arready, 0);
    chk({tag, "_sarvalid"}, s_arvalid, 0);
    chk({tag, "_srready"}, s_rready, 0);
    chk({tag, "_rvalid"}, m_rvalid, 0);
    chk({tag, "_rlast"}, m_rlast, 0);
    chk({tag, "_rresp"}, m_rresp, 0);
    chk({tag, "_sel"}, s_sel, 0);
    chk({tag, "_araddr"}, s_araddr, 0);
    chk({tag, "_arid"}, s_arid, 0);
    chk({tag, "_arlen"}, s_arlen, 0);
    chk({tag, "_rid"}, m_rid, 0);
  endtask

  // One complete read seen from the master side; abort_beat >= 0 asserts rst on that beat.
  task automatic txn(input logic [2:0] reqs, input logic [2:0] pend, input int stall,
                     input int rmode, input int abort_beat);
    int w, beats, got, cyc;
    logic [3:0] sel;
    logic [2:0] ev;
    w = exp_winner(reqs);
    sel = dec_of(a_addr[w]);
    beats = int'(a_len[w]) + 1;
    got = 0;
    cyc = 0;
    @(negedge clk);
    m_arvalid = reqs; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 3'b000;
    #1;
    chk("grant", m_arready, 3'b001 << w);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    m_arvalid = pend;
    #1;
    chk("dec_busy", busy, 1);
    chk("dec_addr", dec_addr, a_addr[w]);
    chk("dec_sarvalid", s_arvalid, 0);
    chk("dec_arready", m_arready, 0);
    if (sel != 4'd6) begin
      for (int i = 0; i <= stall; i++) begin
        @(negedge clk);
        s_arready = (i == stall); s_rvalid = 1'($urandom); m_rready = 3'($urandom); m_arvalid = pend;
        #1;
        chk("addr_sarvalid", s_arvalid, 1);
        chk("addr_araddr", s_araddr, a_addr[w]);
        chk("addr_arid", s_arid, {w[1:0], a_id[w]});
        chk("addr_arlen", s_arlen, a_len[w]);
        chk("addr_sel", s_sel, sel);
        chk("addr_rvalid", m_rvalid, 0);
        chk("addr_srready", s_rready, 0);
        chk("addr_arready", m_arready, 0);
      end
      while (got < beats && cyc < 300) begin
        @(negedge clk);
        s_arready = 1'b0; m_arvalid = pend;
        s_rvalid = (abort_beat >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        s_rlast = (got == beats - 1); s_rresp = 2'($urandom);
        m_rready = rready_pat(rmode, cyc);
        #1;
        if (got == abort_beat) begin
          rst = 1'b1;
          #1;
          check_reset("abort");
          return;
        end
        ev = s_rvalid ? (3'b001 << w) : 3'b000;
        chk("data_rvalid", m_rvalid, ev);
        chk("data_srready", s_rready, m_rready[w]);
        chk("data_rlast", m_rlast, s_rlast);
        chk("data_rresp", m_rresp, s_rresp);
        chk("data_rid", m_rid, a_id[w]);
        chk("data_sarvalid", s_arvalid, 0);
        chk("data_arready", m_arready, 0);
        if (s_rvalid && m_rready[w]) got++;
        cyc++;
      end
    end else begin
      while (got < beats && cyc < 300) begin
        @(negedge clk);
        s_arready = 1'($urandom); s_rvalid = 1'($urandom); s_rlast = 1'($urandom);
        m_rready = rready_pat(rmode, cyc); m_arvalid = pend;
        #1;
        chk("err_rvalid", m_rvalid, 3'b001 << w);
        chk("err_rresp", m_rresp, 2'b11);
        chk("err_rlast", m_rlast, got == beats - 1);
        chk("err_sarvalid", s_arvalid, 0);
        chk("err_srready", s_rready, 0);
        chk("err_sel", s_sel, 4'd6);
        chk("err_arready", m_arready, 0);
        if (m_rready[w]) got++;
        cyc++;
      end
    end
    chk("beats", got, beats);
    mptr = (w + 1) % 3;
  endtask

  task automatic set_master(input int m, input bit unmapped);
    a_addr[m] = rand_addr(unmapped);
    a_id[m]   = 4'($urandom);
    a_len[m]  = 4'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    m_arvalid = 3'b000; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    s_rresp = 2'b00; m_rready = 3'b000;
    for (int m = 0; m < 3; m++) set_master(m, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // Single mapped read from M1
    a_addr[1] = 32'h0001_0040; a_len[1] = 4'd3; a_id[1] = 4'hA;
    txn(3'b010, 3'b000, 0, 0, -1);

    // Unmapped read from M2 with toggling rready
    a_addr[2] = 32'h3000_0000; a_len[2] = 4'd2;
    txn(3'b100, 3'b000, 0, 2, -1);

    // AR backpressure on M0
    set_master(0, 1'b0);
    txn(3'b001, 3'b000, 5, 1, -1);

    // M2 waits while M0 is busy, then wins right after rlast
    set_master(0, 1'b0); set_master(2, 1'b0);
    txn(3'b001, 3'b100, 1, 1, -1);
    txn(3'b100, 3'b000, 0, 1, -1);

    // Contention: all three request continuously
    for (int r = 0; r < 4; r++) begin
      for (int m = 0; m < 3; m++) set_master(m, $urandom_range(0, 3) == 0);
      txn(3'b111, 3'b111, 0, 1, -1);
    end

    // Randomized traffic
    for (int r = 0; r < 10; r++) begin
      logic [2:0] rq;
      for (int m = 0; m < 3; m++) set_master(m, $urandom_range(0, 3) == 0);
      rq = 3'($urandom_range(1, 7));
      txn(rq, 3'($urandom), $urandom_range(0, 3), 1, -1);
    end

    // Longest DECERR burst
    a_addr[1] = 32'h3ABC_0000; a_len[1] = 4'd15;
    txn(3'b010, 3'b000, 0, 1, -1);

    // Reset during second beat, then pointer restarts at M0
    set_master(1, 1'b0);
    txn(3'b010, 3'b000, 0, 0, -1);
    set_master(0, 1'b0); a_len[0] = 4'd3;
    txn(3'b001, 3'b000, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    mptr = 0;
    for (int m = 0; m < 3; m++) set_master(m, 1'b0);
    txn(3'b111, 3'b000, 0, 1, -1);

    @(negedge clk);
    m_arvalid = 3'b000; s_rvalid = 1'b0; m_rready = 3'b000;
    #1;
    chk("final_busy", busy, 0);
    chk("final_arready", m_arready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_ar_arbiter.md
# axi_ar_arbiter

Read-address channel arbiter and read-transaction sequencer for the AXI interconnect. It shares one downstream read path between three masters: M0 (instruction fetch), M1 (data) and M2 (DMA). It grants one master at a time and resolves the target through the external address decoder. It holds the grant until the final R beat completes. Reads to unmapped space (default slave) are answered locally with DECERR beats.

## Interface
- ADDR_W, 32, address width
- ID_W, 4, master-side ARID width
- LEN_W, 4, ARLEN width (bursts of 1..16 beats)
- DEF_SLV, 6, decoder slave ID meaning "unmapped"
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- m_arvalid  in  3  per-master AR valid
- m_araddr  in  3*ADDR_W  per-master address, master m at bits [m*ADDR_W +: ADDR_W]
- m_arid  in  3*ID_W  per-master ARID
- m_arlen  in  3*LEN_W  per-master ARLEN
- m_arready  out  3  per-master AR ready, at most one bit high
- dec_addr  out  ADDR_W  address presented to the external decoder
- dec_slave_id  in  4  decoder result for dec_addr (combinational)
- s_arvalid  out  1  downstream AR valid
- s_arready  in  1  downstream AR ready
- s_araddr  out  ADDR_W  latched address
- s_arid  out  ID_W+2  {grant index, latched ARID}
- s_arlen  out  LEN_W  latched ARLEN
- s_sel  out  4  registered slave ID, used by the external AR/R muxes
- s_rvalid, s_rlast  in  1, 1  downstream R handshake and last beat
- s_rresp  in  2  downstream response
- s_rready  out  1  downstream R ready
- m_rvalid  out  3  per-master R valid, at most one bit high
- m_rready  in  3  per-master R ready
- m_rlast  out  1  shared R last
- m_rresp  out  2  shared R response
- m_rid  out  ID_W  shared R ID, always the latched ARID
- busy  out  1  high when state is not IDLE

## Operation
- FSM states:
  - IDLE, DEC, ADDR, DATA, ERR
- IDLE:
  - The winner is chosen combinationally among the set m_arvalid bits.
  - m_arready[winner]=1 in the same cycle.
  - On that edge the block latches grant, addr, id and len, then moves to DEC.
  - If no request is pending, the block stays in IDLE.
- DEC:
  - dec_addr = latched addr. In all other states dec_addr holds the latched addr as well.
  - s_sel <= dec_slave_id.
  - Next state is ERR if dec_slave_id == DEF_SLV, otherwise ADDR.
- ADDR:
  - s_arvalid=1 until s_arvalid & s_arready, then the block moves to DATA.
  - s_araddr, s_arid and s_arlen stay stable while s_arvalid is high.
- DATA:
  - m_rvalid[grant] = s_rvalid; s_rready = m_rready[grant].
  - m_rlast = s_rlast; m_rresp = s_rresp.
  - On s_rvalid & s_rready & s_rlast the block moves to IDLE.
- ERR:
  - m_rvalid[grant]=1 and m_rresp=2'b11 (DECERR).
  - A beat counter of width LEN_W+1 counts accepted beats.
  - m_rlast=1 when count == len.
  - On the last accepted beat the counter clears and the block moves to IDLE.
  - The downstream side is untouched: s_arvalid=0, s_rready=0.
- On return to IDLE the round-robin pointer updates to grant+1 mod 3.
- Requests that arrive while busy see m_arready=0 and wait. A master that drops arvalid before its grant is simply not selected.
- s_rvalid seen outside DATA is ignored; s_rready=0.
- The block performs no length check on the slave: s_rlast alone ends DATA.

## Timing
- Reset values:
  - State IDLE, round-robin pointer 0, s_sel=0.
  - Latched fields 0, counter 0.
  - All valid, ready and last outputs 0; busy=0.
- Reset asserted mid-transaction aborts immediately and asynchronously. The bench re-initialises the slaves.
- Latency:
  - AR handshake on master side at cycle 0.
  - DEC at cycle 1.
  - s_arvalid first high at cycle 2.
  - Minimum occupancy is AR + DEC + ADDR + beats.
- Back-to-back: the earliest next master grant is in the cycle after the last R beat. The IDLE arbitration cycle is itself the next grant cycle.
- Burst length is ARLEN+1 beats. ARLEN=15 gives 16 DECERR beats. The counter never wraps within a burst.

## Configuration
- ARB_RR_EN defined: round-robin; the search starts at the pointer, then pointer+1 and pointer+2 (mod 3).
- ARB_RR_EN undefined: fixed priority M0 > M1 > M2; the pointer is not implemented.

## Test plan
- Single read: M1 requests addr 0x0001_0040, len 3; decoder returns 1. Required: m_arready[1] at cycle 0, s_arvalid at cycle 2, s_sel=1, s_arid={2'd1, id}, 4 beats routed to M1, busy drops after the rlast beat.
- Contention: all three masters request every cycle with ARB_RR_EN defined. Required grant order M0, M1, M2, M0. With the macro undefined, M0 is granted every time.
- Unmapped read: M2 requests addr 0x3000_0000, len 2. Required: s_arvalid never asserts, 3 beats with m_rresp=2'b11, m_rlast only on the third beat. With m_rready toggled 1,0,1,0,1 the beats still total 3.
- Backpressure: s_arready held low 5 cycles. Required: s_arvalid and s_araddr stable throughout. With m_rready[0]=0 during DATA, s_rready=0.
- Busy blocking: M0 transfer in DATA while M2 asserts arvalid. Required: m_arready[2] stays 0 until DATA exits; M2 is granted in the cycle after rlast.
- Reset mid-burst: rst asserted during the second beat of a 4-beat read. Required: outputs go to reset values in the same cycle, and after release the next request is granted normally from pointer 0.
